// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control/handshake bundle between multicycle_sequencer and its datapath
interface multicycle_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stall_in;
  logic [6:0]           opcode_in;
  logic                 zero_in;
  logic                 imem_ack_in;
  logic                 dmem_ack_in;
  logic                 imem_req_out;
  logic                 ir_write_out;
  logic                 dmem_req_out;
  logic                 dmem_we_out;
  logic                 reg_write_out;
  logic                 pc_write_out;
  logic                 pc_src_out;
  logic                 illegal_out;
  logic                 mem_err_out;
  logic [2:0]           state_out;
  logic [CNT_WIDTH-1:0] retired_cnt_out;

  modport master (
    input  stall_in, opcode_in, zero_in, imem_ack_in, dmem_ack_in,
    output imem_req_out, ir_write_out, dmem_req_out, dmem_we_out, reg_write_out,
           pc_write_out, pc_src_out, illegal_out, mem_err_out, state_out, retired_cnt_out
  );

  modport slave (
    output stall_in, opcode_in, zero_in, imem_ack_in, dmem_ack_in,
    input  imem_req_out, ir_write_out, dmem_req_out, dmem_we_out, reg_write_out,
           pc_write_out, pc_src_out, illegal_out, mem_err_out, state_out, retired_cnt_out
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM
// Optional retired-instruction counter enabled by SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_sequencer_if.master bus
);
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam int         WW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout;

  logic imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, pc_src, illegal, mem_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pending_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    pending_d = 1'b0;
    wait_d    = '0;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      FETCH: begin
        // once a request is out it must stay up until acked, whatever stall does
        imem_req = !bus.stall_in || pending_q;
        if (bus.imem_ack_in) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else begin
          pending_d = imem_req;
        end
      end
      DECODE: begin
        if (bus.opcode_in inside {OP_LD, OP_SD, OP_R, OP_BEQ}) begin
          state_d = EXECUTE;
        end else begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end
      end
      EXECUTE: begin
        case (bus.opcode_in)
          OP_R:         state_d = WRITEBACK;
          OP_LD, OP_SD: state_d = MEM;
          OP_BEQ: begin
            pc_write = 1'b1;
            pc_src   = bus.zero_in;
            state_d  = FETCH;
          end
          default: begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (bus.opcode_in == OP_SD);
        if (bus.dmem_ack_in) begin
          if (dmem_we) begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (timeout) begin
          mem_err  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // outputs stay quiet for the whole reset cycle, whatever state we were in
    if (reset) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      illegal   = 1'b0;
      mem_err   = 1'b0;
    end
  end

  assign bus.imem_req_out  = imem_req;
  assign bus.ir_write_out  = ir_write;
  assign bus.dmem_req_out  = dmem_req;
  assign bus.dmem_we_out   = dmem_we;
  assign bus.reg_write_out = reg_write;
  assign bus.pc_write_out  = pc_write;
  assign bus.pc_src_out    = pc_src;
  assign bus.illegal_out   = illegal;
  assign bus.mem_err_out   = mem_err;
  assign bus.state_out     = reset ? 3'd0 : state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (pc_write && !illegal && !mem_err) begin
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign bus.retired_cnt_out = retired_q;
`else
  assign bus.retired_cnt_out = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_WIDTH   = 32;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [CNT_WIDTH-1:0] exp_cnt = '0;

  multicycle_sequencer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  multicycle_sequencer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] quiet_vec();
    return {bus.imem_req_out, bus.ir_write_out, bus.dmem_req_out, bus.dmem_we_out,
            bus.reg_write_out, bus.pc_write_out, bus.pc_src_out, bus.illegal_out,
            bus.mem_err_out, |bus.state_out};
  endfunction

  // Builds the expected cycle-by-cycle state walk of one instruction from the
  // architectural rules, drives it, and tallies what the DUT did against it.
  task automatic run_instr(input logic [6:0] opc, input int stall_n, input int iack_d,
                           input int dack_d, input logic zero);
    int  st[$];
    bit  stl[$], ia[$], da[$];
    bit  legal, mem_op, tout, retire;
    int  mem_n;
    int  n_ireq = 0, n_irw = 0, n_dreq = 0, n_dwe = 0, n_rw = 0, n_rw_bad = 0;
    int  n_pcw = 0, n_ill = 0, n_err = 0, n_both = 0, pcw_idx = -1;
    logic pcs = 1'b0;

    legal  = opc inside {OP_LD, OP_SD, OP_R, OP_BEQ};
    mem_op = (opc == OP_LD) || (opc == OP_SD);
    tout   = mem_op && (dack_d >= MEM_TIMEOUT);
    mem_n  = tout ? MEM_TIMEOUT : dack_d + 1;
    retire = legal && !tout;

    for (int i = 0; i < stall_n; i++) begin
      st.push_back(0); stl.push_back(1'b1); ia.push_back(1'b0); da.push_back(1'b0);
    end
    for (int j = 0; j <= iack_d; j++) begin
      st.push_back(0);
      stl.push_back((j == 0) ? 1'b0 : ($urandom % 4 != 0));
      ia.push_back(j == iack_d);
      da.push_back(1'b0);
    end
    st.push_back(1); stl.push_back($urandom % 2); ia.push_back(1'b0); da.push_back(1'b0);
    if (legal) begin
      st.push_back(2); stl.push_back($urandom % 2); ia.push_back(1'b0); da.push_back(1'b0);
      if (mem_op) begin
        for (int k = 0; k < mem_n; k++) begin
          st.push_back(3); stl.push_back($urandom % 2); ia.push_back(1'b0);
          da.push_back(!tout && (k == dack_d));
        end
      end
      if (opc == OP_R || (opc == OP_LD && !tout)) begin
        st.push_back(4); stl.push_back($urandom % 2); ia.push_back(1'b0); da.push_back(1'b0);
      end
    end

    for (int idx = 0; idx < st.size(); idx++) begin
      @(posedge clk); #1;
      bus.stall_in    = stl[idx];
      bus.imem_ack_in = ia[idx];
      bus.dmem_ack_in = da[idx];
      bus.opcode_in   = opc;
      bus.zero_in     = zero;
      @(negedge clk);
      if (idx == 0) check("retired", 64'(bus.retired_cnt_out), 64'(exp_cnt));
      check("state", 64'(bus.state_out), 64'(st[idx]));
      n_ireq   += int'(bus.imem_req_out);
      n_irw    += int'(bus.ir_write_out);
      n_dreq   += int'(bus.dmem_req_out);
      n_dwe    += int'(bus.dmem_req_out && bus.dmem_we_out);
      n_rw     += int'(bus.reg_write_out);
      n_rw_bad += int'(bus.reg_write_out && bus.state_out != 3'd4);
      n_both   += int'(bus.reg_write_out && bus.dmem_req_out);
      n_ill    += int'(bus.illegal_out);
      n_err    += int'(bus.mem_err_out);
      if (bus.pc_write_out) begin
        n_pcw++;
        pcw_idx = idx;
        pcs     = bus.pc_src_out;
      end
    end

    check("imem_req_cycles", 64'(n_ireq), 64'(iack_d + 1));
    check("ir_write_cnt", 64'(n_irw), 64'd1);
    check("dmem_req_cycles", 64'(n_dreq), 64'(mem_op ? mem_n : 0));
    check("dmem_we_cycles", 64'(n_dwe), 64'((opc == OP_SD) ? mem_n : 0));
    check("reg_write_cnt", 64'(n_rw), 64'((opc == OP_R || (opc == OP_LD && !tout)) ? 1 : 0));
    check("reg_write_outside_wb", 64'(n_rw_bad), 64'd0);
    check("reg_dmem_overlap", 64'(n_both), 64'd0);
    check("pc_write_cnt", 64'(n_pcw), 64'd1);
    check("pc_write_last_cycle", 64'(pcw_idx), 64'(st.size() - 1));
    check("pc_src", 64'(pcs), 64'((opc == OP_BEQ) ? zero : 1'b0));
    check("illegal_cnt", 64'(n_ill), 64'(legal ? 0 : 1));
    check("mem_err_cnt", 64'(n_err), 64'(tout ? 1 : 0));
`ifdef SEQ_PERF_CNT_EN
    if (retire) exp_cnt = exp_cnt + 1'b1;
`else
    if (retire) exp_cnt = exp_cnt;
`endif
  endtask

  task automatic reset_in_mem();
    int exp_st[6] = '{0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.stall_in    = 1'b0;
      bus.imem_ack_in = (i == 0);
      bus.dmem_ack_in = 1'b0;
      bus.opcode_in   = OP_LD;
      @(negedge clk);
      check("rst_mem_walk", 64'(bus.state_out), 64'(exp_st[i]));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mem_quiet", 64'(quiet_vec()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.stall_in = 1'b1;
    @(negedge clk);
    check("rst_mem_state", 64'(bus.state_out), 64'd0);
    check("rst_mem_dmem_req", 64'(bus.dmem_req_out), 64'd0);
    check("rst_mem_reg_write", 64'(bus.reg_write_out), 64'd0);
    check("rst_mem_retired", 64'(bus.retired_cnt_out), 64'd0);
    exp_cnt = '0;
  endtask

  initial begin
    logic [6:0] opc;
    reset           = 1'b1;
    bus.stall_in    = 1'b0;
    bus.opcode_in   = 7'd0;
    bus.zero_in     = 1'b0;
    bus.imem_ack_in = 1'b0;
    bus.dmem_ack_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(quiet_vec()), 64'd0);
    check("reset_retired", 64'(bus.retired_cnt_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.stall_in = 1'b1;
    @(negedge clk);
    check("post_reset_state", 64'(bus.state_out), 64'd0);
    check("post_reset_stalled_req", 64'(bus.imem_req_out), 64'd0);

    run_instr(OP_R, 0, 0, 0, 1'b0);
    run_instr(OP_LD, 0, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 0, 1'b0);
    run_instr(OP_SD, 0, 1, 1000, 1'b0);
    run_instr(7'b1111111, 0, 0, 0, 1'b0);
    run_instr(OP_R, 5, 0, 0, 1'b1);
    run_instr(OP_SD, 0, 4, 0, 1'b0);
    run_instr(OP_LD, 1, 2, MEM_TIMEOUT - 1, 1'b0);
    run_instr(OP_LD, 0, 0, MEM_TIMEOUT, 1'b1);
    reset_in_mem();

    for (int n = 0; n < 60; n++) begin
      case ($urandom % 5)
        0: opc = OP_LD;
        1: opc = OP_SD;
        2: opc = OP_R;
        3: opc = OP_BEQ;
        default: begin
          opc = 7'($urandom);
          if (opc inside {OP_LD, OP_SD, OP_R, OP_BEQ}) opc = 7'b1111111;
        end
      endcase
      run_instr(opc, int'($urandom % 3), int'($urandom % 4), int'($urandom % 20), 1'($urandom));
    end

    @(posedge clk); #1;
    bus.stall_in    = 1'b1;
    bus.imem_ack_in = 1'b0;
    bus.dmem_ack_in = 1'b0;
    @(negedge clk);
    check("final_retired", 64'(bus.retired_cnt_out), 64'(exp_cnt));
    check("final_state", 64'(bus.state_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
